// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and a word-wide, big-endian
// DataMemory with active-low strobes. One request in flight at a time.
// Sub-word stores are done as read-modify-write. Bad requests return an error
// response without strobing memory.
module mem_access_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP, ERR} stateT;

  stateT       state;
  logic [1:0]  lSize;
  logic [1:0]  lOff;
  logic        lSigned;
  logic [15:0] lWData;    // only the low half is merged; word stores use ReqWData directly

  logic [32:0] wordEnd;
  logic        reqErr;
  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [31:0] loadVal;
  logic [31:0] mergeVal;

  // Validate the incoming request: reserved size, misalignment, or a word that runs past the end of memory
  always_comb begin
    wordEnd = {1'b0, ReqAddr[31:2], 2'b00} + 33'd3;
    reqErr  = (ReqSize == 2'b11)
           || (ReqSize == 2'b01 && ReqAddr[0])
           || (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00)
           || (wordEnd >= 33'(MEM_BYTES));
  end

  // Big-endian lane select for loads and lane replace for read-modify-write
  always_comb begin
    case (lOff)
      2'd0:    selByte = MemReadData[31:24];
      2'd1:    selByte = MemReadData[23:16];
      2'd2:    selByte = MemReadData[15:8];
      default: selByte = MemReadData[7:0];
    endcase
    selHalf = lOff[1] ? MemReadData[15:0] : MemReadData[31:16];

    case (lSize)
      2'b00:   loadVal = {{24{lSigned & selByte[7]}}, selByte};
      2'b01:   loadVal = {{16{lSigned & selHalf[15]}}, selHalf};
      default: loadVal = MemReadData;
    endcase

    mergeVal = MemReadData;
    if (lSize == 2'b00) begin
      case (lOff)
        2'd0:    mergeVal[31:24] = lWData[7:0];
        2'd1:    mergeVal[23:16] = lWData[7:0];
        2'd2:    mergeVal[15:8]  = lWData[7:0];
        default: mergeVal[7:0]   = lWData[7:0];
      endcase
    end else if (lOff[1]) begin
      mergeVal[15:0] = lWData;
    end else begin
      mergeVal[31:16] = lWData;
    end
  end

  // Access sequencer; every output is registered alongside the state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      ReqReady     <= 1'b1;
      RespValid    <= 1'b0;
      RespError    <= 1'b0;
      RespRData    <= '0;
      MemRead      <= 1'b1;
      MemWrite     <= 1'b1;
      MemAddress   <= '0;
      MemWriteData <= '0;
      lSize        <= '0;
      lOff         <= '0;
      lSigned      <= 1'b0;
      lWData       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            ReqReady <= 1'b0;
            lSize    <= ReqSize;
            lOff     <= ReqAddr[1:0];
            lSigned  <= ReqSigned;
            lWData   <= ReqWData[15:0];
            if (reqErr) begin
              state     <= ERR;
              RespValid <= 1'b1;
              RespError <= 1'b1;
              RespRData <= '0;
            end else begin
              MemAddress <= {ReqAddr[31:2], 2'b00};
              if (!ReqWrite) begin
                state   <= RD;
                MemRead <= 1'b0;
              end else if (ReqSize == 2'b10) begin
                state        <= WR;
                MemWrite     <= 1'b0;
                MemWriteData <= ReqWData;
              end else begin
                state   <= RMW_RD;
                MemRead <= 1'b0;
              end
            end
          end
        end
        RD: begin
          MemRead   <= 1'b1;
          RespRData <= loadVal;
          RespValid <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          MemRead      <= 1'b1;
          MemWrite     <= 1'b0;
          MemWriteData <= mergeVal;
          state        <= RMW_WR;
        end
        RMW_WR, WR: begin
          MemWrite  <= 1'b1;
          RespValid <= 1'b1;
          RespRData <= '0;
          state     <= RESP;
        end
        RESP, ERR: begin
          RespValid <= 1'b0;
          RespError <= 1'b0;
          RespRData <= '0;
          ReqReady  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory with big-endian word port,
// plus a reference byte array updated from the access rules directly.
module tb_mem_access_unit;
  localparam int MB = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqWData;
  logic        RespValid, RespError;
  logic [31:0] RespRData, MemAddress, MemWriteData, MemReadData;
  logic        MemRead, MemWrite;

  always #5 CLK = ~CLK;

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .CLK(CLK), .RST(RST),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .RespError(RespError),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  logic [7:0] mem    [MB];
  logic [7:0] refMem [MB];

  // Combinational big-endian word read
  always_comb begin
    MemReadData = '0;
    if (MemAddress <= 32'(MB - 4)) begin
      for (int i = 0; i < 4; i++)
        MemReadData[31-8*i -: 8] = mem[int'(MemAddress[15:0]) + i];
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic        pendW = 1'b0;
  logic [31:0] pendA, pendD;
  logic [31:0] expAddr = '0;
  logic [31:0] lastWData = '0;
  int          rdLow, wrLow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: commit a pending write into memory, then sample outputs after the edge
  task automatic tick();
    @(posedge CLK);
    if (pendW === 1'b1 && pendA <= 32'(MB - 4))
      for (int i = 0; i < 4; i++) mem[int'(pendA[15:0]) + i] = pendD[31-8*i -: 8];
    #1;
    if (MemRead === 1'b0) rdLow++;
    if (MemWrite === 1'b0) begin wrLow++; lastWData = MemWriteData; end
    if (MemRead === 1'b0 || MemWrite === 1'b0) begin
      chk("strobeAddr", MemAddress, expAddr);
      chk("strobeExcl", 32'(MemRead | MemWrite), 32'd1);
    end
    pendW = (MemWrite === 1'b0);
    pendA = MemAddress;
    pendD = MemWriteData;
  endtask

  function automatic logic refErr(input logic [1:0] sz, input logic [31:0] a);
    longint wa;
    wa = longint'(a) / 4 * 4;
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (wa + 3 >= MB);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(refMem[int'(a) + i]);
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) refMem[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
  endtask

  task automatic setWord(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a+i]    = w[31-8*i -: 8];
      refMem[a+i] = w[31-8*i -: 8];
    end
  endtask

  // Full transaction: issue, bound the wait for the response, check timing, data and strobes
  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic e;
    logic [31:0] exp;
    int expLat, expRd, expWr, lat;
    chk("readyIdle", 32'(ReqReady), 32'd1);
    e      = refErr(sz, a);
    exp    = (!e && !w) ? refLoad(a, sz, sg) : 32'd0;
    expLat = e ? 1 : (w && sz != 2'd2) ? 3 : 2;
    expRd  = (!e && (!w || sz != 2'd2)) ? 1 : 0;
    expWr  = (!e && w) ? 1 : 0;
    if (!e && w) refStore(a, sz, wd);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    rdLow = 0; wrLow = 0;
    expAddr = {a[31:2], 2'b00};
    tick();
    ReqValid = 1'b0;
    lat = 1;
    while (RespValid !== 1'b1 && lat < 10) begin tick(); lat++; end
    chk("latency", 32'(lat), 32'(expLat));
    chk("respErr", 32'(RespError), 32'(e));
    chk("respData", RespRData, exp);
    rd = RespRData;
    tick();
    chk("respPulse", 32'(RespValid), 32'd0);
    chk("readyBack", 32'(ReqReady), 32'd1);
    chk("rdStrobes", 32'(rdLow), 32'(expRd));
    chk("wrStrobes", 32'(wrLow), 32'(expWr));
  endtask

  initial begin
    logic [31:0] r, expA, expB;
    RST = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0;
    for (int i = 0; i < MB; i++) begin
      mem[i]    = 8'($urandom);
      refMem[i] = mem[i];
    end
    setWord(8, 32'h11223344);
    setWord(12, 32'h80F00102);

    // Reset state
    tick(); tick();
    chk("rstReady", 32'(ReqReady), 32'd1);
    chk("rstRespValid", 32'(RespValid), 32'd0);
    chk("rstRespError", 32'(RespError), 32'd0);
    chk("rstRData", RespRData, 32'd0);
    chk("rstMemRead", 32'(MemRead), 32'd1);
    chk("rstMemWrite", 32'(MemWrite), 32'd1);
    chk("rstMemAddr", MemAddress, 32'd0);
    chk("rstMemWData", MemWriteData, 32'd0);
    RST = 1'b1;
    tick();

    // Word load
    doReq(1'b0, 2'd2, 1'b0, 32'd8, 32'd0, r);   chk("lw8", r, 32'h11223344);
    // Sub-word loads, signed and unsigned
    doReq(1'b0, 2'd0, 1'b1, 32'd13, 32'd0, r);  chk("lb13", r, 32'hFFFFFFF0);
    doReq(1'b0, 2'd0, 1'b0, 32'd13, 32'd0, r);  chk("lbu13", r, 32'h000000F0);
    doReq(1'b0, 2'd1, 1'b1, 32'd14, 32'd0, r);  chk("lh14", r, 32'h00000102);
    doReq(1'b0, 2'd1, 1'b1, 32'd12, 32'd0, r);  chk("lh12", r, 32'hFFFF80F0);
    doReq(1'b0, 2'd1, 1'b0, 32'd12, 32'd0, r);  chk("lhu12", r, 32'h000080F0);
    // Read-modify-write stores
    doReq(1'b1, 2'd0, 1'b0, 32'd13, 32'h000000AB, r);
    chk("sbWData", lastWData, 32'h80AB0102);
    doReq(1'b1, 2'd1, 1'b0, 32'd14, 32'h00001234, r);
    chk("shWData", lastWData, 32'h80AB1234);
    chk("shMemWord", {mem[12], mem[13], mem[14], mem[15]}, 32'h80AB1234);
    // Word store
    doReq(1'b1, 2'd2, 1'b0, 32'd20, 32'hCAFEF00D, r);
    chk("swWData", lastWData, 32'hCAFEF00D);
    // Errors; the word at 60 is the last one in range, 64 is past the end
    doReq(1'b0, 2'd2, 1'b0, 32'd6, 32'd0, r);
    doReq(1'b1, 2'd1, 1'b0, 32'd5, 32'h5555, r);
    doReq(1'b0, 2'd3, 1'b0, 32'd0, 32'd0, r);
    doReq(1'b0, 2'd2, 1'b0, 32'd64, 32'd0, r);
    doReq(1'b1, 2'd0, 1'b0, 32'd66, 32'h77, r);
    doReq(1'b0, 2'd2, 1'b0, 32'd60, 32'd0, r);

    // Request held during a busy load is not taken until the unit returns to idle
    expA = refLoad(32'd8, 2'd2, 1'b0);
    expB = refLoad(32'd15, 2'd0, 1'b0);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'd2; ReqSigned = 1'b0; ReqAddr = 32'd8;
    expAddr = 32'd8;
    tick();
    ReqSize = 2'd0; ReqAddr = 32'd15;
    chk("busyReady", 32'(ReqReady), 32'd0);
    tick();
    chk("busyResp", 32'(RespValid), 32'd1);
    chk("busyRDataA", RespRData, expA);
    chk("busyReady2", 32'(ReqReady), 32'd0);
    tick();
    chk("idleReady", 32'(ReqReady), 32'd1);
    chk("idleNoResp", 32'(RespValid), 32'd0);
    expAddr = 32'd12;
    tick();
    ReqValid = 1'b0;
    chk("bAccepted", 32'(ReqReady), 32'd0);
    chk("bReadLow", 32'(MemRead), 32'd0);
    tick();
    chk("bResp", 32'(RespValid), 32'd1);
    chk("bRData", RespRData, expB);
    tick();

    // Reset during the read half of a read-modify-write aborts with memory untouched
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqAddr = 32'd21; ReqWData = 32'h000000EE;
    expAddr = 32'd20;
    tick();
    ReqValid = 1'b0;
    chk("rmwRdLow", 32'(MemRead), 32'd0);
    RST = 1'b0;
    tick();
    chk("abortMemRead", 32'(MemRead), 32'd1);
    chk("abortMemWrite", 32'(MemWrite), 32'd1);
    chk("abortResp", 32'(RespValid), 32'd0);
    chk("abortReady", 32'(ReqReady), 32'd1);
    RST = 1'b1;
    tick(); tick();
    chk("abortNoResp", 32'(RespValid), 32'd0);

    // Randomized traffic including misaligned, reserved and out-of-range requests
    for (int n = 0; n < 60; n++) begin
      doReq(1'(($urandom % 2)), 2'($urandom_range(0, 3)), 1'(($urandom % 2)),
            32'($urandom_range(0, 71)), $urandom, r);
    end

    for (int i = 0; i < MB; i++) chk("memByte", 32'(mem[i]), 32'(refMem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
